instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 62 ++++++
 tb/tb_instr_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: step-triggered sequencer that issues stored instructions over a valid/ready handshake
//   clk, rst_n            : clock, asynchronous active-low reset
//   step                  : step request level; each rising edge issues one instruction
//   load_en/addr/data     : program memory write port, honoured only while idle
//   last_idx              : final program index, pc wraps to 0 after it
//   instr/valid/ready     : instruction handshake towards the coprocessor
//   pc, busy, overrun     : next index, non-idle indicator, sticky dropped-step flag
module instr_sequencer #(
  parameter int IW = 22,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic [AW-1:0] last_idx,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          overrun
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
  state_t state, state_nx;
  logic step_q;
  logic step_edge;
  logic [IW-1:0] mem [2**AW];
  assign step_edge = step & ~step_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE  ? (step_edge ? FETCH : IDLE) :
               state == FETCH ? ISSUE :
               (instr_ready ? IDLE : ISSUE);
  end
  always_comb begin
    busy        = state != IDLE;
    instr_valid = state == ISSUE;
  end
  // pc >= last_idx also catches a pc left beyond a shrunk program
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q  <= 1'b0;
      pc      <= '0;
      instr   <= '0;
      overrun <= 1'b0;
    end else begin
      step_q <= step;
      if (state == FETCH) instr <= mem[pc];
      if (state == ISSUE && instr_ready) pc <= pc >= last_idx ? '0 : pc + 1'b1;
      if (step_edge && state != IDLE) overrun <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (load_en && state == IDLE) mem[load_addr] <= load_data;
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: scoreboard bench with a transaction-level model of the sequencer
module tb_instr_sequencer;
  localparam int IW = 22;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step = 1'b0;
  logic load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [IW-1:0] load_data = '0;
  logic [AW-1:0] last_idx = '0;
  logic instr_ready = 1'b0;
  logic [IW-1:0] instr;
  logic instr_valid;
  logic [AW-1:0] pc;
  logic busy;
  logic overrun;
  always #5 clk = ~clk;
  instr_sequencer #(.IW(IW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .step(step), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .last_idx(last_idx), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .busy(busy), .overrun(overrun)
  );
  typedef struct packed {
    logic [IW-1:0] i;
    logic [AW-1:0] p;
  } exp_t;
  exp_t exp_q[$];
  logic [IW-1:0] m_mem [32];
  logic [IW-1:0] m_last;
  logic [IW-1:0] m_cur;
  int m_pc;
  int m_valid_at;
  int cyc = 0;
  bit m_busy;
  bit m_ovr;
  bit m_prev;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic model_reset();
    exp_q.delete();
    m_pc = 0;
    m_busy = 0;
    m_ovr = 0;
    m_prev = 0;
    m_last = '0;
  endtask
  // One instruction per accepted edge: issued from two cycles after the edge until ready,
  // and every edge seen while an instruction is outstanding is lost and flagged.
  task automatic model_adv();
    bit e;
    e = step && !m_prev;
    m_prev = step;
    if (m_busy) begin
      if (cyc >= m_valid_at && instr_ready) begin
        m_pc = m_pc >= int'(last_idx) ? 0 : m_pc + 1;
        m_busy = 0;
        m_last = m_cur;
      end
      if (e) m_ovr = 1;
    end else begin
      if (load_en) m_mem[load_addr] = load_data;
      if (e) begin
        m_busy = 1;
        m_valid_at = cyc + 2;
        m_cur = m_mem[m_pc];
        exp_q.push_back('{m_cur, AW'(m_pc)});
      end
    end
    cyc++;
  endtask
  task automatic tick(input bit s, input bit le = 0, input int la = 0, input int ld = 0, input bit rdy = 1);
    @(posedge clk);
    #1;
    if (rst_n) model_adv();
    step = s;
    load_en = le;
    load_addr = AW'(la);
    load_data = IW'(ld);
    instr_ready = rdy;
  endtask
  always @(negedge clk) begin
    bit ev;
    if (rst_n) begin
      ev = m_busy && cyc >= m_valid_at;
      chk("valid", 32'(instr_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (!m_busy) chk("instr_hold", 32'(instr), 32'(m_last));
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard: valid with nothing expected, instr %0h", instr);
        end else begin
          chk("instr", 32'(instr), 32'(exp_q[0].i));
          chk("issue_pc", 32'(pc), 32'(exp_q[0].p));
          if (instr_ready) void'(exp_q.pop_front());
        end
      end
    end
  end
  initial begin
    model_reset();
    #3;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) tick(0, 1, a, int'($urandom));
    tick(0, 1, 0, 'h200804);
    tick(0, 1, 1, 'h000003);
    tick(0);
    last_idx = AW'(1);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      repeat (4) tick(0);
      chk("seq_pc", 32'(pc), k == 1 ? 32'd0 : 32'd1);
      chk("seq_instr", 32'(instr), k == 1 ? 32'h000003 : 32'h200804);
    end
    tick(1, 0, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    repeat (3) tick(0, 0, 0, 0, 0);
    tick(0);
    repeat (3) tick(0);
    chk("stall_overrun", 32'(overrun), 32'd1);
    chk("stall_pc", 32'(pc), 32'd0);
    repeat (20) tick(1);
    repeat (3) tick(0);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 1, m_pc, 'h3FFFFF, 0);
    tick(0);
    repeat (3) tick(0);
    repeat (2) begin
      tick(1);
      repeat (4) tick(0);
    end
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_instr", 32'(instr), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_overrun", 32'(overrun), 32'd0);
    model_reset();
    tick(1);
    rst_n = 1'b1;
    repeat (5) tick(0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) last_idx = AW'($urandom_range(0, 31));
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, int'($urandom_range(0, 31)),
           int'($urandom), $urandom_range(0, 2) != 0);
    end
    repeat (6) tick(0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
